uart_word_packer: RTL and testbench

UART_WORD_PACKER -- requirements
Module: uart_word_packer

---
 rtl/disp_pkg.sv | 17 +
 rtl/pack_timer.sv | 41 ++++
 rtl/uart_word_packer.sv | 103 ++++++++++
 tb/tb_uart_word_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the UART word packer and its display path:
// packer state encoding, word geometry and the default inter-byte timeout.
package disp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int unsigned WORD_BYTES          = 4;
    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned BYTE_CNT_W          = $clog2(WORD_BYTES);
    localparam int unsigned PART_W              = (WORD_BYTES - 1) * BYTE_W;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 1000000;
    localparam int unsigned TIMER_W             = 24;

endpackage

// File: rtl/pack_timer.sv
// Inter-byte timeout counter for the UART word packer.
// Counts cycles while run=1 and restart=0; expired is a registered flag that
// is high during the cycle in which the count equals TIMEOUT_CYC-1.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset
//   run     - packer is collecting a partial word
//   restart - byte accepted or clear; count returns to 0
//   expired - count has reached TIMEOUT_CYC-1 this cycle
module pack_timer
    import disp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] count;

    // expired is precomputed from the next count so it stays a flop output;
    // an expiry cycle also returns the count to 0 since the packer goes idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (!run || restart || expired) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count + TIMER_W'(1);
            expired <= ((count + TIMER_W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs a stream of UART bytes big-endian into 32-bit words for the
// 7-segment display driver. Partial bytes are held internally; disp_data only
// changes when a fourth byte completes a word.
// Optional feature: define UART_WORD_PACKER_TIMEOUT_EN to discard a partial
// word after TIMEOUT_CYC idle cycles and raise the sticky err_timeout flag.
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   rx_data     - received UART byte
//   rx_valid    - one-cycle strobe qualifying rx_data
//   clear       - synchronous discard of partial word and error flag
//   disp_data   - last complete word
//   word_valid  - one-cycle pulse, new word on disp_data
//   byte_cnt    - bytes held in the partial word
//   err_timeout - sticky, partial word discarded by timeout
module uart_word_packer
    import disp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        clear,
    output logic [31:0] disp_data,
    output logic        word_valid,
    output logic [1:0]  byte_cnt,
    output logic        err_timeout
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(WORD_BYTES - 1);

    // Elaboration-time range check on the timeout parameter.
    if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 32'h00FF_FFFF)) begin : g_bad_timeout
        $error("uart_word_packer: TIMEOUT_CYC out of range 2..2^24-1");
    end

    state_t            state;
    logic [PART_W-1:0] partial;

`ifdef UART_WORD_PACKER_TIMEOUT_EN
    logic err_q;
    logic expired;

    pack_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state == COLLECT),
        .restart (clear | rx_valid),
        .expired (expired)
    );

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Priority: clear > rx_valid > timeout expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            partial    <= '0;
            disp_data  <= '0;
            word_valid <= 1'b0;
            byte_cnt   <= '0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                byte_cnt <= '0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
                err_q    <= 1'b0;
`endif
            end else if (rx_valid) begin
                if (byte_cnt == LAST_IDX) begin
                    disp_data  <= {partial, rx_data};
                    word_valid <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= IDLE;
                end else begin
                    // Earlier bytes shift toward the MSBs, giving big-endian order.
                    partial  <= {partial[PART_W-BYTE_W-1:0], rx_data};
                    byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    state    <= COLLECT;
                end
            end
`ifdef UART_WORD_PACKER_TIMEOUT_EN
            else if (expired) begin
                state    <= IDLE;
                byte_cnt <= '0;
                err_q    <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Self-checking bench for uart_word_packer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based model of the byte packing rules.
module tb_uart_word_packer;

    localparam int unsigned T = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        clear;
    logic [31:0] disp_data;
    logic        word_valid;
    logic [1:0]  byte_cnt;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_word_packer #(
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .clear       (clear),
        .disp_data   (disp_data),
        .word_valid  (word_valid),
        .byte_cnt    (byte_cnt),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the partial word in arrival order.
    logic [7:0]  mq[$];
    logic [31:0] m_disp;
    bit          m_wv;
    bit          m_err;
    bit          model_on = 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
    int          m_idle;
`endif

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_disp = '0;
            m_wv   = 1'b0;
            m_err  = 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
            m_idle = 0;
`endif
            model_on = 1'b1;
        end else if (model_on) begin
            m_wv = 1'b0;
            if (clear) begin
                mq.delete();
                m_err = 1'b0;
`ifdef UART_WORD_PACKER_TIMEOUT_EN
                m_idle = 0;
`endif
            end else if (rx_valid) begin
                mq.push_back(rx_data);
`ifdef UART_WORD_PACKER_TIMEOUT_EN
                m_idle = 0;
`endif
                if (mq.size() == 4) begin
                    m_disp = {mq[0], mq[1], mq[2], mq[3]};
                    m_wv   = 1'b1;
                    mq.delete();
                end
            end else begin
`ifdef UART_WORD_PACKER_TIMEOUT_EN
                if (mq.size() > 0) begin
                    if (m_idle == int'(T) - 1) begin
                        mq.delete();
                        m_err  = 1'b1;
                        m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end
`endif
            end
        end
        #1;
        if (model_on) begin
            chk("disp_data",   disp_data,   m_disp);
            chk("word_valid",  32'(word_valid),  32'(m_wv));
            chk("byte_cnt",    32'(byte_cnt),    32'(mq.size()));
            chk("err_timeout", 32'(err_timeout), 32'(m_err));
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        clear    = c;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; clear = 1'b0;
        #2;
        chk("reset_disp",  disp_data, 32'h0);
        chk("reset_bcnt",  32'(byte_cnt), 32'd0);
        chk("reset_wv",    32'(word_valid), 32'd0);
        chk("reset_err",   32'(err_timeout), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single word on consecutive cycles.
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        after_edge();
        chk("w1_valid", 32'(word_valid), 32'd1);
        chk("w1_data",  disp_data, 32'h12345678);
        idle(1);
        after_edge();
        chk("w1_pulse_end", 32'(word_valid), 32'd0);
        chk("w1_hold", disp_data, 32'h12345678);

        // Back-to-back words; byte 5 coincides with word_valid.
        for (int b = 1; b <= 4; b++) send(8'(b));
        after_edge();
        chk("w2_data", disp_data, 32'h01020304);
        for (int b = 5; b <= 8; b++) send(8'(b));
        after_edge();
        chk("w3_data", disp_data, 32'h05060708);
        chk("w3_valid", 32'(word_valid), 32'd1);

        // Clear together with the second byte drops it.
        send(8'hA1);
        drive(1'b1, 8'hB2, 1'b1);
        idle(1);
        chk("clr_bcnt", 32'(byte_cnt), 32'd0);
        chk("clr_disp", disp_data, 32'h05060708);
        chk("clr_err",  32'(err_timeout), 32'd0);
        idle(2);

`ifdef UART_WORD_PACKER_TIMEOUT_EN
        send(8'hAA); send(8'hBB);
        idle(15);
        after_edge();
        chk("to_before_bcnt", 32'(byte_cnt), 32'd2);
        chk("to_before_err",  32'(err_timeout), 32'd0);
        idle(1);
        after_edge();
        chk("to_bcnt", 32'(byte_cnt), 32'd0);
        chk("to_err",  32'(err_timeout), 32'd1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        after_edge();
        chk("to_word", disp_data, 32'h11223344);
        chk("to_sticky", 32'(err_timeout), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
        chk("to_cleared", 32'(err_timeout), 32'd0);
        send(8'h01); send(8'h02);
        idle(15);
        send(8'h03);
        after_edge();
        chk("race_bcnt", 32'(byte_cnt), 32'd3);
        chk("race_err",  32'(err_timeout), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
`else
        send(8'hC1); send(8'hC2);
        idle(40);
        after_edge();
        chk("hold_bcnt", 32'(byte_cnt), 32'd2);
        chk("hold_err",  32'(err_timeout), 32'd0);
        chk("hold_disp", disp_data, 32'h05060708);
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
`endif

        // Reset mid-word, then a full word after release.
        send(8'h01); send(8'h02);
        @(negedge clk);
        rx_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_disp", disp_data, 32'h0);
        chk("rst_bcnt", 32'(byte_cnt), 32'd0);
        chk("rst_wv",   32'(word_valid), 32'd0);
        chk("rst_err",  32'(err_timeout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        after_edge();
        chk("rst_word", disp_data, 32'hDEADBEEF);

        // Randomized phase with varying strobe density and rare clears.
        for (int blk = 0; blk < 30; blk++) begin
            int pv;
            pv = int'($urandom_range(0, 90));
            for (int i = 0; i < 100; i++) begin
                drive(($urandom % 100) < pv, 8'($urandom_range(0, 255)),
                      ($urandom % 200) == 0);
            end
        end

        idle(4);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
